// File: rtl/fbuf_swap_arbiter.sv
// Double-buffered framebuffer port arbiter: display reads the front bank,
// writer fills the back bank, banks exchange on end-of-frame after a request.
module fbuf_swap_arbiter #(
  parameter int FBUF_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vde,
  input  logic                       eof,
  input  logic [FBUF_ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [FBUF_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       swap_req,
  output logic                       swap_pending,
  output logic                       front_sel,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [FBUF_ADDR_WIDTH:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_SWAP
  } state_t;

  state_t state;
  logic   accept;
  logic   rd_pend;

  // The display always wins the port; writes stall while a swap waits.
  assign wr_ready  = !vde && !swap_pending && (state != WAIT_SWAP);
  assign accept    = wr_valid && wr_ready;
  assign mem_en    = vde || accept;
  assign mem_we    = accept;
  assign mem_addr  = vde ? {front_sel, rd_addr} : {~front_sel, wr_addr};
  assign mem_wdata = wr_data;

  // Write/swap control FSM; a frame boundary only counts once a swap is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap_pending && eof) begin
      state        <= IDLE;
      front_sel    <= ~front_sel;
      swap_pending <= 1'b0;
    end else if (swap_req && !swap_pending) begin
      state        <= WAIT_SWAP;
      swap_pending <= 1'b1;
    end else if (state != WAIT_SWAP) begin
      state <= accept ? WRITE : IDLE;
    end
  end

  // Two-stage read return: issue, then capture the memory's one-cycle data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= vde;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fbuf_swap_arbiter.sv
// Scoreboard bench for fbuf_swap_arbiter with a behavioural single-port RAM.
// Writes and reads are queued when driven and retired when the DUT responds.
module tb_fbuf_swap_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vde;
  logic        eof;
  logic [7:0]  rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        swap_req;
  logic        swap_pending;
  logic        front_sel;
  logic        mem_en;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;

  fbuf_swap_arbiter #(.FBUF_ADDR_WIDTH(8), .DATA_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .vde(vde), .eof(eof),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_pending(swap_pending),
    .front_sel(front_sel), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [23:0] d;
  } wexp_t;

  typedef struct {
    logic [23:0] d;
    int          c;
  } rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  logic [23:0] ram [0:511];
  logic [23:0] ref_mem [0:511];
  logic        exp_front;
  int          cyc;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [23:0] d);
    wexp_t e;
    e.a = {~exp_front, a};
    e.d = d;
    wq.push_back(e);
    ref_mem[e.a] = d;
  endtask

  task automatic push_rd(input logic [7:0] a);
    rexp_t e;
    e.d = ref_mem[{exp_front, a}];
    e.c = cyc;
    rq.push_back(e);
  endtask

  // External memory: one-cycle registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Retire queued expectations as the DUT produces memory writes and pixels.
  always @(negedge clk) begin
    if (!rst) begin
      chk("we_vde", {31'd0, mem_we & vde}, 32'd0);
      if (vde) begin
        chk("rd_en", {31'd0, mem_en}, 32'd1);
        chk("rd_maddr", {23'd0, mem_addr}, {23'd0, exp_front, rd_addr});
      end
      if (mem_we) begin
        chk("wq_nonempty", {31'd0, wq.size() != 0}, 32'd1);
        if (wq.size() != 0) begin
          chk("wr_maddr", {23'd0, mem_addr}, {23'd0, wq[0].a});
          chk("wr_mdata", {8'd0, mem_wdata}, {8'd0, wq[0].d});
          void'(wq.pop_front());
        end
      end
      if (rq.size() != 0 && rq[0].c + 2 <= cyc)
        chk("rd_valid_due", {31'd0, rd_valid}, 32'd1);
      if (rd_valid) begin
        chk("rq_nonempty", {31'd0, rq.size() != 0}, 32'd1);
        if (rq.size() != 0) begin
          chk("rd_lat", cyc, rq[0].c + 2);
          chk("rd_data", {8'd0, rd_data}, {8'd0, rq[0].d});
          void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    exp_front = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 512; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    ram[5] = 24'h123456;
    ref_mem[5] = 24'h123456;
    rst = 1'b1; vde = 1'b0; eof = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;

    @(negedge clk);
    chk("rst_front", {31'd0, front_sel}, 32'd0);
    chk("rst_pend", {31'd0, swap_pending}, 32'd0);
    chk("rst_rvalid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rdata", {8'd0, rd_data}, 32'd0);
    chk("rst_wready", {31'd0, wr_ready}, 32'd1);
    chk("rst_men", {31'd0, mem_en}, 32'd0);
    tick();
    rst = 1'b0;

    // Three back-to-back writes into the back bank.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr = 8'h10 + 8'(i);
      wr_data = 24'hA0 + 24'(i);
      push_wr(wr_addr, wr_data);
      @(negedge clk);
      chk("wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("wr_we", {31'd0, mem_we}, 32'd1);
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("idle_men", {31'd0, mem_en}, 32'd0);
    chk("idle_mwe", {31'd0, mem_we}, 32'd0);
    tick();

    // Single display read with two-cycle latency.
    vde = 1'b1;
    rd_addr = 8'h05;
    push_rd(rd_addr);
    tick();
    vde = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rd_drop", {31'd0, rd_valid}, 32'd0);
    chk("rd_hold", {8'd0, rd_data}, 32'h123456);
    tick();

    // Swap request, 20 cycles of waiting, then end of frame.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      wr_valid = (i < 20);
      wr_addr = 8'h33;
      wr_data = 24'h333333;
      swap_req = (i == 5);
      eof = (i == 20);
      @(negedge clk);
      chk("wait_pend", {31'd0, swap_pending}, 32'd1);
      chk("wait_wready", {31'd0, wr_ready}, 32'd0);
      chk("wait_front", {31'd0, front_sel}, 32'd0);
      tick();
    end
    eof = 1'b0;
    swap_req = 1'b0;
    wr_valid = 1'b0;
    exp_front = 1'b1;
    @(negedge clk);
    chk("swap_front", {31'd0, front_sel}, 32'd1);
    chk("swap_pend", {31'd0, swap_pending}, 32'd0);
    chk("swap_wready", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_addr = 8'h40;
    wr_data = 24'h55AA55;
    push_wr(wr_addr, wr_data);
    tick();
    wr_valid = 1'b0;
    vde = 1'b1;
    rd_addr = 8'h11;
    push_rd(rd_addr);
    tick();
    rd_addr = 8'h05;
    push_rd(rd_addr);
    tick();
    vde = 1'b0;
    tick();
    tick();

    // Request and frame end together: swap deferred one frame.
    swap_req = 1'b1;
    eof = 1'b1;
    tick();
    swap_req = 1'b0;
    eof = 1'b0;
    @(negedge clk);
    chk("same_front", {31'd0, front_sel}, 32'd1);
    chk("same_pend", {31'd0, swap_pending}, 32'd1);
    tick();
    tick();
    tick();
    eof = 1'b1;
    tick();
    eof = 1'b0;
    exp_front = 1'b0;
    @(negedge clk);
    chk("next_front", {31'd0, front_sel}, 32'd0);
    chk("next_pend", {31'd0, swap_pending}, 32'd0);
    tick();

    // Writer held while the display takes the port for four cycles.
    wr_valid = 1'b1;
    wr_addr = 8'h77;
    wr_data = 24'h777777;
    for (int i = 0; i < 4; i++) begin
      vde = 1'b1;
      rd_addr = 8'h40 + 8'(i);
      push_rd(rd_addr);
      @(negedge clk);
      chk("vde_wready", {31'd0, wr_ready}, 32'd0);
      tick();
    end
    vde = 1'b0;
    push_wr(wr_addr, wr_data);
    @(negedge clk);
    chk("post_vde_we", {31'd0, mem_we}, 32'd1);
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    tick();

    // Bring bank 1 to the front, then reset mid swap-wait with reads in flight.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    eof = 1'b1;
    tick();
    eof = 1'b0;
    exp_front = 1'b1;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    vde = 1'b1;
    rd_addr = 8'h11;
    push_rd(rd_addr);
    tick();
    rd_addr = 8'h12;
    push_rd(rd_addr);
    tick();
    vde = 1'b0;
    tick();
    chk("pre_rvalid", {31'd0, rd_valid}, 32'd1);
    chk("pre_pend", {31'd0, swap_pending}, 32'd1);
    chk("pre_front", {31'd0, front_sel}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pend", {31'd0, swap_pending}, 32'd0);
    chk("arst_front", {31'd0, front_sel}, 32'd0);
    chk("arst_rvalid", {31'd0, rd_valid}, 32'd0);
    rq.delete();
    exp_front = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    wr_valid = 1'b1;
    wr_addr = 8'h01;
    wr_data = 24'h0BADF0;
    push_wr(wr_addr, wr_data);
    tick();
    wr_valid = 1'b0;
    tick();
    tick();

    chk("wq_left", wq.size(), 32'd0);
    chk("rq_left", rq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fbuf_swap_arbiter.md
FBUF_SWAP_ARBITER -- requirements
Module: fbuf_swap_arbiter

Interface
REQ-001 SHALL have parameter FBUF_ADDR_WIDTH, default 8, pixel address width within one framebuffer bank.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, pixel word width (RGB888).
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port vde  in  1  display active; display owns the memory port while high.
REQ-006 SHALL have port eof  in  1  one-cycle end-of-frame pulse from the display timing chain.
REQ-007 SHALL have port rd_addr  in  FBUF_ADDR_WIDTH  display pixel address, sampled when vde=1.
REQ-008 SHALL have port rd_data  out  DATA_WIDTH  registered display pixel.
REQ-009 SHALL have port rd_valid  out  1  rd_data qualifier.
REQ-010 SHALL have port wr_valid / wr_ready  in / out  1 / 1  writer handshake.
REQ-011 SHALL have port wr_addr  in  FBUF_ADDR_WIDTH  back-bank write address.
REQ-012 SHALL have port wr_data  in  DATA_WIDTH  write pixel.
REQ-013 SHALL have port swap_req  in  1  pulse requesting front/back exchange.
REQ-014 SHALL have port swap_pending  out  1  swap requested, not yet executed.
REQ-015 SHALL have port front_sel  out  1  bank currently displayed.
REQ-016 SHALL have port mem_en, mem_we  out  1 each  single-port memory controls.
REQ-017 SHALL have port mem_addr  out  FBUF_ADDR_WIDTH+1  MSB = bank bit, LSBs = pixel address.
REQ-018 SHALL have port mem_wdata / mem_rdata  out / in  DATA_WIDTH  memory data; mem_rdata is valid 1 cycle after a read enable.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, WAIT_SWAP, registered.
REQ-020 IDLE: vde=0, no pending swap; wr_ready=1; wr_valid=1 -> WRITE for that beat.
REQ-021 WRITE: accepted beat drives mem_en=1, mem_we=1, mem_addr={~front_sel, wr_addr}, mem_wdata=wr_data in the acceptance cycle; back-to-back beats allowed, returning to IDLE when wr_valid=0.
REQ-022 Transfer occurs only when wr_valid=1 and wr_ready=1 in the same cycle; wr_ready is combinational from state, vde and swap_pending.
REQ-023 While vde=1, display owns the port: mem_en=1, mem_we=0, mem_addr={front_sel, rd_addr}, wr_ready=0, regardless of FSM state.
REQ-024 Read latency: rd_addr at cycle N -> rd_data valid, rd_valid=1 at cycle N+2; rd_valid=0 otherwise; rd_data holds last value when not valid.
REQ-025 swap_req with swap_pending=0 SHALL set swap_pending next cycle and move FSM to WAIT_SWAP; wr_ready=0 in WAIT_SWAP.
REQ-026 swap_req while swap_pending=1 SHALL be ignored (no queueing).
REQ-027 eof with swap_pending=1: front_sel toggles, swap_pending clears, FSM -> IDLE, all on the next edge.
REQ-028 swap_req and eof in the same cycle with swap_pending=0: no swap that frame; pending set, swap at the next eof.
REQ-029 eof with swap_pending=0 SHALL have no effect.
REQ-030 vde rising while wr_valid=1: display wins that cycle; beat not accepted, writer holds.
REQ-031 With no access, mem_en=0, mem_we=0; mem_we SHALL never be 1 while vde=1.

Reset
REQ-032 On rst=1, asynchronously: FSM=IDLE, front_sel=0, swap_pending=0, rd_valid=0, rd_data=0, read pipeline cleared; wr_ready, mem_en, mem_we follow combinationally (0 while vde=1).
REQ-033 rst asserted mid-write or mid-swap-wait SHALL abort: no pending swap, bank 0 front after release.

Verification
REQ-034 vde=0, three writes addr 0x10..0x12 data 0xA0..0xA2 -> mem_we=1 three consecutive cycles, mem_addr 0x110..0x112 (front_sel=0).
REQ-035 vde=1, rd_addr=0x05 at cycle N, mem_rdata=0x123456 at N+1 -> rd_data=0x123456, rd_valid=1 at N+2; mem_addr=0x005.
REQ-036 swap_req, then eof 20 cycles later -> swap_pending=1 for 20 cycles, wr_ready=0 throughout, front_sel=1 after eof; next write uses mem_addr MSB=0.
REQ-037 swap_req and eof same cycle -> front_sel unchanged; toggles only at the following eof.
REQ-038 wr_valid=1 held, vde toggles 1 for 4 cycles -> no mem_we during vde=1; beat accepted first cycle vde=0.
REQ-039 rst pulse during WAIT_SWAP -> swap_pending=0, front_sel=0, rd_valid=0 immediately (asynchronously).
